// File: rtl/i2s_pkg.sv
// Shared definitions for the i2s sample FIFO: FIFO state encoding and default sample width.
package i2s_pkg;

    localparam int DATA_BIT_DEFAULT = 16;

    typedef enum logic {
        PRIME = 1'b0,
        RUN   = 1'b1
    } state_t;

endpackage

// File: rtl/i2s_fifo_ram.sv
// Frame storage for the i2s sample FIFO: synchronous write, asynchronous read, contents not reset.
module i2s_fifo_ram #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/i2s_sample_fifo.sv
// Stereo sample FIFO between a frame producer and an i2s transmitter; withholds samples
// (sending silence) until PRIME frames are buffered and re-primes after an underflow.
module i2s_sample_fifo #(
    parameter int DATA_BIT = i2s_pkg::DATA_BIT_DEFAULT,
    parameter int DEPTH    = 16,
    parameter int PRIME    = DEPTH / 2
) (
    input  logic                     i_clk_12_288,
    input  logic                     i_reset_n,
    input  logic                     i_wr_valid,
    output logic                     o_wr_ready,
    input  logic [DATA_BIT-1:0]      i_wr_l,
    input  logic [DATA_BIT-1:0]      i_wr_r,
    input  logic                     i_data_ready,
    input  logic                     i_flush,
    output logic [DATA_BIT-1:0]      o_audio_l,
    output logic [DATA_BIT-1:0]      o_audio_r,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_underflow,
    output logic                     o_priming
);

    import i2s_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] DEPTH_LVL = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] PRIME_LVL = LVL_W'(PRIME);

    state_t                    state;
    state_t                    state_nx;
    logic [PTR_W-1:0]          wr_ptr;
    logic [PTR_W-1:0]          rd_ptr;
    logic [2*DATA_BIT-1:0]     rd_frame;
    logic                      push;
    logic                      pop;
    logic                      underflow_evt;
    logic                      in_run;

    assign in_run        = (state == i2s_pkg::RUN);
    assign o_wr_ready    = (o_level < DEPTH_LVL) && !i_flush;
    assign push          = i_wr_valid && o_wr_ready;
    // A request is judged against the registered level, so a same-cycle push into an
    // empty FIFO cannot rescue it: the request underflows and the push is still stored.
    assign pop           = in_run && i_data_ready && (o_level != '0) && !i_flush;
    assign underflow_evt = in_run && i_data_ready && (o_level == '0) && !i_flush;

    i2s_fifo_ram #(
        .WIDTH (2 * DATA_BIT),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (i_clk_12_288),
        .we      (push),
        .wr_addr (wr_ptr),
        .wr_data ({i_wr_l, i_wr_r}),
        .rd_addr (rd_ptr),
        .rd_data (rd_frame)
    );

    always_ff @(posedge i_clk_12_288 or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state <= i2s_pkg::PRIME;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        if (i_flush) begin
            state_nx = i2s_pkg::PRIME;
        end else begin
            case (state)
                i2s_pkg::PRIME: if (o_level >= PRIME_LVL) state_nx = i2s_pkg::RUN;
                i2s_pkg::RUN:   if (underflow_evt)        state_nx = i2s_pkg::PRIME;
                default:                                  state_nx = i2s_pkg::PRIME;
            endcase
        end
    end

    always_comb begin
        o_priming = (state == i2s_pkg::PRIME);
    end

    always_ff @(posedge i_clk_12_288 or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            o_level <= '0;
        end else if (i_flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            o_level <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   o_level <= o_level + LVL_W'(1);
                2'b01:   o_level <= o_level - LVL_W'(1);
                default: o_level <= o_level;
            endcase
        end
    end

    // Output samples only move on a request (or flush/reset) and hold in between, giving
    // the transmitter one full request period of latency.
    always_ff @(posedge i_clk_12_288 or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_audio_l   <= '0;
            o_audio_r   <= '0;
            o_underflow <= 1'b0;
        end else if (i_flush) begin
            o_audio_l   <= '0;
            o_audio_r   <= '0;
            o_underflow <= 1'b0;
        end else begin
            o_underflow <= underflow_evt;
            if (i_data_ready) begin
                if (pop) begin
                    o_audio_l <= rd_frame[2*DATA_BIT-1:DATA_BIT];
                    o_audio_r <= rd_frame[DATA_BIT-1:0];
                end else begin
                    o_audio_l <= '0;
                    o_audio_r <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_i2s_sample_fifo.sv
// Directed bench for i2s_sample_fifo (DEPTH 16, PRIME 8) with hand-computed expectations.
module tb_i2s_sample_fifo;

    localparam int DB    = 16;
    localparam int DEPTH = 16;
    localparam int PRIME = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_valid;
    logic          wr_ready;
    logic [DB-1:0] wr_l;
    logic [DB-1:0] wr_r;
    logic          data_ready;
    logic          flush;
    logic [DB-1:0] audio_l;
    logic [DB-1:0] audio_r;
    logic [4:0]    level;
    logic          underflow;
    logic          priming;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    i2s_sample_fifo #(
        .DATA_BIT (DB),
        .DEPTH    (DEPTH),
        .PRIME    (PRIME)
    ) dut (
        .i_clk_12_288 (clk),
        .i_reset_n    (rst_n),
        .i_wr_valid   (wr_valid),
        .o_wr_ready   (wr_ready),
        .i_wr_l       (wr_l),
        .i_wr_r       (wr_r),
        .i_data_ready (data_ready),
        .i_flush      (flush),
        .o_audio_l    (audio_l),
        .o_audio_r    (audio_r),
        .o_level      (level),
        .o_underflow  (underflow),
        .o_priming    (priming)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int l, input int r);
        wr_valid = 1'b1;
        wr_l     = DB'(l);
        wr_r     = DB'(r);
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic pop();
        data_ready = 1'b1;
        tick();
        data_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; wr_valid = 1'b0; wr_l = '0; wr_r = '0;
        data_ready = 1'b0; flush = 1'b0;
        #12;
        chk("rst_level", level, 0);
        chk("rst_priming", priming, 1);
        chk("rst_wr_ready", wr_ready, 1);
        chk("rst_audio_l", audio_l, 0);
        chk("rst_underflow", underflow, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Requests while priming give silence
        for (int i = 0; i < 3; i++) begin
            pop();
            chk("prime_audio_l", audio_l, 0);
            chk("prime_audio_r", audio_r, 0);
            chk("prime_priming", priming, 1);
            chk("prime_underflow", underflow, 0);
        end

        // Fill to the prime level; RUN follows one edge later
        for (int k = 1; k <= 8; k++) begin
            push(k, k + 1);
            chk("fill_level", level, k);
        end
        chk("fill_still_priming", priming, 1);
        tick();
        chk("fill_run", priming, 0);
        pop();
        chk("first_l", audio_l, 1);
        chk("first_r", audio_r, 2);
        chk("first_level", level, 7);
        pop();
        chk("second_l", audio_l, 2);
        chk("second_r", audio_r, 3);

        // Fill to full, refuse a 17th frame, pop once
        for (int k = 9; k <= 18; k++) push(k, k + 1);
        chk("full_level", level, 16);
        chk("full_wr_ready", wr_ready, 0);
        wr_valid = 1'b1; wr_l = 16'hAA; wr_r = 16'hBB;
        tick();
        chk("full_reject_level", level, 16);
        data_ready = 1'b1;
        #1;
        chk("full_pop_wr_ready", wr_ready, 0);
        tick();
        chk("full_pop_level", level, 15);
        chk("full_pop_l", audio_l, 3);
        chk("full_ready_rises", wr_ready, 1);
        wr_valid = 1'b0; data_ready = 1'b0;
        tick();
        chk("full_no_extra", level, 15);

        // Drain to 5, then simultaneous push/pop across the pointer wrap
        for (int i = 0; i < 10; i++) pop();
        chk("drain_l", audio_l, 13);
        chk("drain_level", level, 5);
        for (int j = 0; j < 5; j++) begin
            wr_valid = 1'b1; wr_l = DB'(19 + j); wr_r = DB'(20 + j);
            data_ready = 1'b1;
            tick();
            wr_valid = 1'b0; data_ready = 1'b0;
            chk("wrap_l", audio_l, 14 + j);
            chk("wrap_r", audio_r, 15 + j);
            chk("wrap_level", level, 5);
        end

        // Drain to 1, then run dry
        for (int i = 0; i < 4; i++) pop();
        chk("dry_pre_l", audio_l, 22);
        chk("dry_pre_level", level, 1);
        pop();
        chk("dry_last_l", audio_l, 23);
        chk("dry_last_r", audio_r, 24);
        chk("dry_last_underflow", underflow, 0);
        chk("dry_last_priming", priming, 0);
        pop();
        chk("under_l", audio_l, 0);
        chk("under_r", audio_r, 0);
        chk("under_pulse", underflow, 1);
        chk("under_priming", priming, 1);
        tick();
        chk("under_pulse_end", underflow, 0);

        // Push into an empty FIFO coincident with a RUN request
        for (int k = 30; k < 38; k++) push(k, k + 1);
        tick();
        chk("re_run", priming, 0);
        for (int i = 0; i < 8; i++) pop();
        chk("re_drain_l", audio_l, 37);
        chk("re_drain_level", level, 0);
        wr_valid = 1'b1; wr_l = 16'd40; wr_r = 16'd41; data_ready = 1'b1;
        tick();
        wr_valid = 1'b0; data_ready = 1'b0;
        chk("coinc_underflow", underflow, 1);
        chk("coinc_audio_l", audio_l, 0);
        chk("coinc_level", level, 1);
        chk("coinc_priming", priming, 1);

        // Flush beats a concurrent write and request
        for (int k = 41; k < 50; k++) push(k, k + 1);
        chk("pre_flush_level", level, 10);
        tick();
        pop();
        chk("pre_flush_l", audio_l, 40);
        push(50, 51);
        chk("pre_flush_level2", level, 10);
        flush = 1'b1; wr_valid = 1'b1; wr_l = 16'h77; wr_r = 16'h78; data_ready = 1'b1;
        #1;
        chk("flush_wr_ready", wr_ready, 0);
        tick();
        flush = 1'b0; wr_valid = 1'b0; data_ready = 1'b0;
        chk("flush_level", level, 0);
        chk("flush_audio_l", audio_l, 0);
        chk("flush_audio_r", audio_r, 0);
        chk("flush_priming", priming, 1);
        chk("flush_underflow", underflow, 0);
        tick();
        chk("flush_underflow_after", underflow, 0);
        for (int k = 60; k < 68; k++) push(k, k + 1);
        tick();
        pop();
        chk("post_flush_l", audio_l, 60);
        chk("post_flush_level", level, 7);

        // Asynchronous reset mid-stream
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_level", level, 0);
        chk("arst_audio_l", audio_l, 0);
        chk("arst_audio_r", audio_r, 0);
        chk("arst_priming", priming, 1);
        chk("arst_wr_ready", wr_ready, 1);
        chk("arst_underflow", underflow, 0);
        tick();
        rst_n = 1'b1;
        for (int k = 70; k < 78; k++) push(k, k + 1);
        tick();
        pop();
        chk("post_arst_l", audio_l, 70);
        chk("post_arst_r", audio_r, 71);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
